// File: rtl/nrisc_ula_pkg.sv
// Shared constants for the NRISC ALU issue/writeback sequencer:
// widths, ALU opcodes, flag bit positions and the sequencer state encoding.
package nrisc_ula_pkg;

  localparam int TAM_DEFAULT  = 16;
  localparam int NREG_DEFAULT = 8;
  localparam int RW_DEFAULT   = 3;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHR = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  // Bit 3 of the control word turns a shift into a rotate.
  localparam logic [3:0] OP_ROT = 4'h8;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_M = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/nrisc_regfile.sv
// General register file: NREG x TAM, one synchronous write port,
// three asynchronous read ports (operand A, operand B, debug), reset to zero.
module nrisc_regfile
  import nrisc_ula_pkg::*;
#(
  parameter int TAM  = TAM_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int RW   = RW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [RW-1:0]   waddr_i,
  input  logic [TAM-1:0]  wdata_i,
  input  logic [RW-1:0]   raddrA_i,
  output logic [TAM-1:0]  rdataA_o,
  input  logic [RW-1:0]   raddrB_i,
  output logic [TAM-1:0]  rdataB_o,
  input  logic [RW-1:0]   raddrDbg_i,
  output logic [TAM-1:0]  rdataDbg_o
);

  logic [TAM-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdataA_o   = regs_q[raddrA_i];
  assign rdataB_o   = regs_q[raddrB_i];
  assign rdataDbg_o = regs_q[raddrDbg_i];

endmodule

// File: rtl/nrisc_ula_seq.sv
// Issue/writeback sequencer for the registered NRISC ALU: reads operands from
// the register file, drives the ALU, and writes the result and flags back.
module nrisc_ula_seq
  import nrisc_ula_pkg::*;
#(
  parameter int TAM  = TAM_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int RW   = RW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [3:0]      instr_op,
  input  logic [RW-1:0]   instr_rd,
  input  logic [RW-1:0]   instr_rs,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [RW-1:0]   ld_addr,
  input  logic [TAM-1:0]  ld_data,
  output logic [TAM-1:0]  ULA_A,
  output logic [TAM-1:0]  ULA_B,
  output logic [3:0]      ULA_ctrl,
  input  logic [TAM-1:0]  ULA_OUT,
  input  logic [2:0]      ULA_flags,
  output logic            wb_valid,
  output logic [RW-1:0]   wb_addr,
  output logic [TAM-1:0]  wb_data,
  output logic [2:0]      flags,
  output logic            busy,
  input  logic [RW-1:0]   dbg_addr,
  output logic [TAM-1:0]  dbg_data
);

  seq_state_e     state_q, state_d;
  logic [TAM-1:0] ulaA_q, ulaB_q;
  logic [3:0]     ulaCtrl_q;
  logic [RW-1:0]  rdHold_q;
  logic [2:0]     flags_q;

  logic           instrFire;
  logic           rfWe;
  logic [RW-1:0]  rfWaddr;
  logic [TAM-1:0] rfWdata;
  logic [TAM-1:0] rdDataA, rdDataB;

  nrisc_regfile #(
    .TAM (TAM),
    .NREG(NREG),
    .RW  (RW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (rfWe),
    .waddr_i   (rfWaddr),
    .wdata_i   (rfWdata),
    .raddrA_i  (instr_rd),
    .rdataA_o  (rdDataA),
    .raddrB_i  (instr_rs),
    .rdataB_o  (rdDataB),
    .raddrDbg_i(dbg_addr),
    .rdataDbg_o(dbg_data)
  );

  // Loads win over instructions in IDLE; the write port is shared between
  // loads (IDLE) and ALU writeback (CAPTURE), which never coincide.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    ld_ready    = 1'b0;
    wb_valid    = 1'b0;
    instrFire   = 1'b0;
    rfWe        = 1'b0;
    rfWaddr     = ld_addr;
    rfWdata     = ld_data;
    case (state_q)
      ST_IDLE: begin
        ld_ready    = 1'b1;
        instr_ready = !ld_valid;
        rfWe        = ld_valid;
        instrFire   = instr_valid && !ld_valid;
        if (instrFire) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        wb_valid = 1'b1;
        rfWe     = 1'b1;
        rfWaddr  = rdHold_q;
        rfWdata  = ULA_OUT;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ulaA_q    <= '0;
      ulaB_q    <= '0;
      ulaCtrl_q <= '0;
      rdHold_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q <= state_d;
      if (instrFire) begin
        ulaA_q    <= rdDataA;
        ulaB_q    <= rdDataB;
        ulaCtrl_q <= instr_op;
        rdHold_q  <= instr_rd;
      end
      if (state_q == ST_CAPTURE) begin
        flags_q <= ULA_flags;
      end
    end
  end

  assign ULA_A    = ulaA_q;
  assign ULA_B    = ulaB_q;
  assign ULA_ctrl = ulaCtrl_q;
  assign wb_addr  = rdHold_q;
  assign wb_data  = ULA_OUT;
  assign flags    = flags_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nrisc_ula_seq.sv
// Self-checking bench for nrisc_ula_seq: a registered ALU model drives the
// result inputs, and a scoreboard queue holds the expected writebacks.
module tb_nrisc_ula_seq;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [2:0]  instr_rd;
  logic [2:0]  instr_rs;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] ULA_A;
  logic [15:0] ULA_B;
  logic [3:0]  ULA_ctrl;
  logic [15:0] ULA_OUT;
  logic [2:0]  ULA_flags;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  flags;
  logic        busy;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    logic [2:0]  flg;
  } wbExp_t;

  wbExp_t      sbQ[$];
  logic [15:0] tbRegs [8];
  logic [2:0]  tbFlags;
  logic [15:0] expA, expB;
  logic [3:0]  expCtrl;
  int          tbPhase;
  int          assertCnt;
  int          failCnt;
  int          acceptCnt;
  int          wbSeen;

  nrisc_ula_seq dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op   (instr_op),
    .instr_rd   (instr_rd),
    .instr_rs   (instr_rs),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ULA_A      (ULA_A),
    .ULA_B      (ULA_B),
    .ULA_ctrl   (ULA_ctrl),
    .ULA_OUT    (ULA_OUT),
    .ULA_flags  (ULA_flags),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flags      (flags),
    .busy       (busy),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Reference ALU: returns {minus, zero, carry, result}.
  function automatic logic [18:0] aluFn(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] r;
    logic [16:0] t;
    logic        c;
    r = '0;
    t = '0;
    c = 1'b0;
    case (op[2:0])
      3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16]; end
      3'd1: begin t = {1'b0, a} - {1'b0, b}; r = t[15:0]; c = t[16]; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = op[3] ? {a[0], a[15:1]} : {1'b0, a[15:1]}; c = a[0]; end
      3'd6: begin r = op[3] ? {a[14:0], a[15]} : {a[14:0], 1'b0}; c = a[15]; end
      default: r = ~a;
    endcase
    return {r[15], (r == 16'h0000), c, r};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    {ULA_flags, ULA_OUT} <= aluFn(ULA_ctrl, ULA_A, ULA_B);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCnt++;
    if (actual !== expected) begin
      failCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 8; i++) tbRegs[i] = '0;
    tbFlags = '0;
    expA    = '0;
    expB    = '0;
    expCtrl = '0;
    tbPhase = 0;
    sbQ.delete();
  endtask

  // One clock cycle: drive inputs, check every observable against the model,
  // then advance the model across the edge.
  task automatic applyStimulus(input bit doLd, input logic [2:0] la, input logic [15:0] ldat,
                               input bit doIn, input logic [3:0] op, input logic [2:0] rd,
                               input logic [2:0] rs, output bit ldAcc, output bit inAcc);
    wbExp_t      newE;
    wbExp_t      capE;
    bit          capture;
    bit          havePop;
    logic [18:0] r;
    logic [2:0]  dbgIdx;
    @(negedge clk);
    ld_valid    = doLd;
    ld_addr     = la;
    ld_data     = ldat;
    instr_valid = doIn;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs    = rs;
    dbgIdx      = 3'($urandom_range(0, 7));
    dbg_addr    = dbgIdx;
    #1;
    ldAcc   = doLd && (tbPhase == 0);
    inAcc   = doIn && !doLd && (tbPhase == 0);
    capture = (tbPhase == 2);
    havePop = 1'b0;
    checkOutput("ld_ready", 32'(ld_ready), 32'(tbPhase == 0));
    checkOutput("instr_ready", 32'(instr_ready), 32'((tbPhase == 0) && !doLd));
    checkOutput("busy", 32'(busy), 32'(tbPhase != 0));
    checkOutput("wb_valid", 32'(wb_valid), 32'(capture));
    checkOutput("flags", 32'(flags), 32'(tbFlags));
    checkOutput("ULA_A", 32'(ULA_A), 32'(expA));
    checkOutput("ULA_B", 32'(ULA_B), 32'(expB));
    checkOutput("ULA_ctrl", 32'(ULA_ctrl), 32'(expCtrl));
    checkOutput("dbg_data", 32'(dbg_data), 32'(tbRegs[dbgIdx]));
    if (wb_valid) wbSeen++;
    if (capture) begin
      checkOutput("sb_depth", 32'(sbQ.size()), 32'd1);
      if (sbQ.size() > 0) begin
        capE    = sbQ.pop_front();
        havePop = 1'b1;
        checkOutput("wb_addr", 32'(wb_addr), 32'(capE.rd));
        checkOutput("wb_data", 32'(wb_data), 32'(capE.data));
      end
    end
    if (inAcc) begin
      r         = aluFn(op, tbRegs[rd], tbRegs[rs]);
      newE.rd   = rd;
      newE.data = r[15:0];
      newE.flg  = r[18:16];
      sbQ.push_back(newE);
      acceptCnt++;
    end
    @(posedge clk);
    if (ldAcc) tbRegs[la] = ldat;
    if (inAcc) begin
      expA    = tbRegs[rd];
      expB    = tbRegs[rs];
      expCtrl = op;
    end
    if (havePop) begin
      tbRegs[capE.rd] = capE.data;
      tbFlags         = capE.flg;
    end
    tbPhase = inAcc ? 1 : ((tbPhase == 1) ? 2 : 0);
  endtask

  task automatic idle(input int n);
    bit l, i;
    for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, l, i);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst         = 1'b1;
    ld_valid    = 1'b0;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearModel();
  endtask

  task automatic loadReg(input logic [2:0] a, input logic [15:0] d);
    bit l, i;
    int n;
    n = 0;
    do begin
      applyStimulus(1'b1, a, d, 1'b0, '0, '0, '0, l, i);
      n++;
    end while (!l && n < 8);
    if (!l) checkOutput("ld_timeout", 32'(l), 32'd1);
  endtask

  task automatic runInstr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
    bit l, i;
    int n;
    n = 0;
    do begin
      applyStimulus(1'b0, '0, '0, 1'b1, op, rd, rs, l, i);
      n++;
    end while (!i && n < 8);
    if (!i) checkOutput("instr_timeout", 32'(i), 32'd1);
    idle(3);
  endtask

  task automatic checkReg(input logic [2:0] a, input logic [15:0] expected, input string tag);
    @(negedge clk);
    ld_valid    = 1'b0;
    instr_valid = 1'b0;
    dbg_addr    = a;
    #1;
    checkOutput(tag, 32'(dbg_data), 32'(expected));
  endtask

  task automatic checkAllRegs(input string tag);
    for (int k = 0; k < 8; k++) checkReg(3'(k), tbRegs[k], tag);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit l, i;
    int wbStart;
    assertCnt   = 0;
    failCnt     = 0;
    acceptCnt   = 0;
    wbSeen      = 0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    ld_valid    = 1'b0;
    instr_op    = '0;
    instr_rd    = '0;
    instr_rs    = '0;
    ld_addr     = '0;
    ld_data     = '0;
    dbg_addr    = '0;
    clearModel();
    repeat (2) @(posedge clk);
    applyReset();
    checkAllRegs("reset_reg");
    idle(2);

    // Load then add.
    loadReg(3'd1, 16'h0005);
    loadReg(3'd2, 16'h0003);
    runInstr(4'h0, 3'd1, 3'd2);
    checkReg(3'd1, 16'h0008, "add_r1");
    checkOutput("add_flags", 32'(flags), 32'(3'b000));

    // Logical ops and subtract.
    loadReg(3'd3, 16'h00F0);
    loadReg(3'd4, 16'h0F0F);
    runInstr(4'h2, 3'd3, 3'd4);
    checkReg(3'd3, 16'h0000, "and_r3");
    checkOutput("and_flags", 32'(flags), 32'(3'b010));
    loadReg(3'd3, 16'h00F0);
    runInstr(4'h3, 3'd3, 3'd4);
    checkReg(3'd3, 16'h0FFF, "or_r3");
    loadReg(3'd3, 16'h00F0);
    runInstr(4'h4, 3'd3, 3'd4);
    checkReg(3'd3, 16'h0FFF, "xor_r3");
    loadReg(3'd3, 16'h0010);
    loadReg(3'd4, 16'h0001);
    runInstr(4'h1, 3'd3, 3'd4);
    checkReg(3'd3, 16'h000F, "sub_r3");

    // Arbitration: load and instruction offered together.
    applyStimulus(1'b1, 3'd5, 16'hBEEF, 1'b1, 4'h0, 3'd5, 3'd2, l, i);
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 4'h0, 3'd5, 3'd2, l, i);
    #1;
    checkOutput("arb_A", 32'(ULA_A), 32'h0000BEEF);
    idle(3);

    // Busy blocking: both valids held high while the sequencer is busy.
    wbStart = wbSeen;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 3'd7, 16'h0000, 1'b1, 4'(k), 3'(k), 3'd7, l, i);
      for (int c = 0; c < 3; c++)
        applyStimulus(1'b1, 3'd7, 16'(16'h1230 + k), 1'b1, 4'h3, 3'd0, 3'd7, l, i);
    end
    idle(1);
    checkOutput("busy_wb_count", 32'(wbSeen - wbStart), 32'd3);

    // Reset in the middle of an instruction.
    loadReg(3'd1, 16'h0005);
    loadReg(3'd2, 16'h0003);
    applyStimulus(1'b0, '0, '0, 1'b1, 4'h0, 3'd1, 3'd2, l, i);
    applyReset();
    idle(3);
    checkAllRegs("rst_mid_reg");
    loadReg(3'd1, 16'h0007);
    loadReg(3'd2, 16'h0009);
    runInstr(4'h0, 3'd1, 3'd2);
    checkReg(3'd1, 16'h0010, "post_rst_add");

    // Self-operand rotate left.
    loadReg(3'd6, 16'h8001);
    applyStimulus(1'b0, '0, '0, 1'b1, 4'hE, 3'd6, 3'd6, l, i);
    #1;
    checkOutput("rot_A", 32'(ULA_A), 32'h00008001);
    checkOutput("rot_B", 32'(ULA_B), 32'h00008001);
    idle(3);
    checkReg(3'd6, 16'h0003, "rot_r6");
    checkOutput("rot_flags", 32'(flags), 32'(3'b001));
    idle(2);
    #1;
    checkOutput("rot_ctrl_hold", 32'(ULA_ctrl), 32'h0000000E);

    // Mixed random traffic over all opcodes.
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1)
        loadReg(3'($urandom_range(0, 7)), 16'($urandom()));
      else
        runInstr(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    checkAllRegs("final_reg");
    idle(1);
    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
